// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: steps the control unit through phases 0..7 and
// supports halt-at-phase-4, resume, single-step mode and a retired-instruction counter.
module phase_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             run_req,
  input  logic             step_mode,
  input  logic             step_req,
  output logic [2:0]       phase,
  output logic             running,
  output logic             halted,
  output logic             step_wait,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALTED    = 2'd1,
    STEP_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   resume;

  // A simultaneous run_req and step_req collapse into one resume.
  assign resume = run_req | step_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      phase       <= 3'd0;
      instr_count <= '0;
      running     <= 1'b1;
      halted      <= 1'b0;
      step_wait   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (phase == 3'd4 && halt) begin
            // Halt wins over step_mode; the instruction parks at phase 4 uncounted.
            state   <= HALTED;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (phase == 3'd7) begin
            phase       <= 3'd0;
            instr_count <= instr_count + CNT_ONE;
            if (step_mode) begin
              state     <= STEP_WAIT;
              running   <= 1'b0;
              step_wait <= 1'b1;
            end
          end else begin
            phase <= phase + 3'd1;
          end
        end
        HALTED: begin
          if (run_req) begin
            state   <= RUN;
            phase   <= 3'd5;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        STEP_WAIT: begin
          if (resume) begin
            state     <= RUN;
            phase     <= 3'd1;
            running   <= 1'b1;
            step_wait <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          phase     <= 3'd0;
          running   <= 1'b1;
          halted    <= 1'b0;
          step_wait <= 1'b0;
        end
      endcase
    end
  end

endmodule
